// File: rtl/csr_pkg.sv
// Shared constants and types for the counter CSRs.
// Holds the CSR address map, the mcountinhibit bit indices, the split
// 64-bit counter type and the ALU counter-read opcodes (also used by ALU decode).
package csr_pkg;

   localparam int unsigned HALF_W = 32;
   localparam int unsigned CNT_W  = 64;
   localparam int unsigned INH_W  = 3;

   // Machine-mode read/write counters
   localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
   localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
   localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
   localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
   localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;

   // User-level read-only shadows
   localparam logic [11:0] CSR_CYCLE         = 12'hC00;
   localparam logic [11:0] CSR_CYCLEH        = 12'hC80;
   localparam logic [11:0] CSR_INSTRET       = 12'hC02;
   localparam logic [11:0] CSR_INSTRETH      = 12'hC82;

   // mcountinhibit bit positions
   localparam int unsigned INH_CY = 0;
   localparam int unsigned INH_IR = 2;

   // ALU counter-read opcodes
   localparam logic [1:0] ALU_RDCYCLE    = 2'd0;
   localparam logic [1:0] ALU_RDCYCLEH   = 2'd1;
   localparam logic [1:0] ALU_RDINSTRET  = 2'd2;
   localparam logic [1:0] ALU_RDINSTRETH = 2'd3;

   typedef struct packed {
      logic [HALF_W-1:0] hi;
      logic [HALF_W-1:0] lo;
   } cnt64_t;

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with independently loadable halves.
// Ports: clk, rst (async high), inc_en (count this edge), we_lo/we_hi
// (load wdata into one half; suppresses the increment), wdata, count (registered).
module csr_counter64
   import csr_pkg::*;
#(
   parameter logic [CNT_W-1:0] RST_VAL = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              inc_en,
   input  logic              we_lo,
   input  logic              we_hi,
   input  logic [HALF_W-1:0] wdata,
   output cnt64_t            count
);

   logic [CNT_W-1:0] count_q;

   // A write to either half wins over the increment; the other half holds.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= RST_VAL;
      end else if (we_lo) begin
         count_q[HALF_W-1:0] <= wdata;
      end else if (we_hi) begin
         count_q[CNT_W-1:HALF_W] <= wdata;
      end else if (inc_en) begin
         count_q <= count_q + CNT_W'(1);
      end
   end

   assign count = count_q;

endmodule

// File: rtl/csr_counter_unit.sv
// Cycle / instret counter unit: owns both 64-bit counters and mcountinhibit,
// exposes them to the ALU and services machine-mode CSR accesses.
// Ports: clk, rst (async high), retire_valid (WB retire strobe),
// csr_we/csr_re/csr_addr/csr_wdata (CSR access), csr_rdata/csr_illegal
// (combinational response), cycle_o/instret_o (registered counter values).
module csr_counter_unit
   import csr_pkg::*;
#(
   parameter int unsigned     XLEN    = 32,
   parameter logic [63:0]     CNT_RST = 64'h0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            retire_valid,
   input  logic            csr_we,
   input  logic            csr_re,
   input  logic [11:0]     csr_addr,
   input  logic [XLEN-1:0] csr_wdata,
   output logic [XLEN-1:0] csr_rdata,
   output logic            csr_illegal,
   output logic [63:0]     cycle_o,
   output logic [63:0]     instret_o
);

   cnt64_t            cycle_q;
   cnt64_t            instret_q;
   logic [INH_W-1:0]  inhibit_q;
   logic              addr_rw;
   logic              addr_ro;
   logic              wr_ok;
   logic [HALF_W-1:0] wdata_h;
   logic [HALF_W-1:0] rdata_h;
   logic              cy_we_lo, cy_we_hi, ir_we_lo, ir_we_hi, inh_we;

   assign wdata_h = HALF_W'(csr_wdata);

   // Address classification
   always_comb begin
      addr_rw = 1'b0;
      addr_ro = 1'b0;
      case (csr_addr)
         CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH,
         CSR_MCOUNTINHIBIT:                                     addr_rw = 1'b1;
         CSR_CYCLE, CSR_CYCLEH, CSR_INSTRET, CSR_INSTRETH:      addr_ro = 1'b1;
         default: ;
      endcase
   end

   // Only writes to RW addresses touch state; illegal writes are dropped.
   assign wr_ok    = csr_we & addr_rw;
   assign cy_we_lo = wr_ok & (csr_addr == CSR_MCYCLE);
   assign cy_we_hi = wr_ok & (csr_addr == CSR_MCYCLEH);
   assign ir_we_lo = wr_ok & (csr_addr == CSR_MINSTRET);
   assign ir_we_hi = wr_ok & (csr_addr == CSR_MINSTRETH);
   assign inh_we   = wr_ok & (csr_addr == CSR_MCOUNTINHIBIT);

   assign csr_illegal = ~rst & ((csr_we & ~addr_rw) | (csr_re & ~(addr_rw | addr_ro)));

   // mcountinhibit: only CY and IR are implemented, bit 1 is hardwired to 0
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inhibit_q <= '0;
      end else if (inh_we) begin
         inhibit_q <= {wdata_h[INH_IR], 1'b0, wdata_h[INH_CY]};
      end
   end

   csr_counter64 #(.RST_VAL(CNT_RST)) u_cycle (
      .clk    (clk),
      .rst    (rst),
      .inc_en (~inhibit_q[INH_CY]),
      .we_lo  (cy_we_lo),
      .we_hi  (cy_we_hi),
      .wdata  (wdata_h),
      .count  (cycle_q)
   );

   csr_counter64 #(.RST_VAL(CNT_RST)) u_instret (
      .clk    (clk),
      .rst    (rst),
      .inc_en (retire_valid & ~inhibit_q[INH_IR]),
      .we_lo  (ir_we_lo),
      .we_hi  (ir_we_hi),
      .wdata  (wdata_h),
      .count  (instret_q)
   );

   // Read mux sees the pre-edge register values, so a same-cycle write is not visible.
   always_comb begin
      rdata_h = '0;
      if (csr_re && !rst) begin
         case (csr_addr)
            CSR_MCYCLE,    CSR_CYCLE:    rdata_h = cycle_q.lo;
            CSR_MCYCLEH,   CSR_CYCLEH:   rdata_h = cycle_q.hi;
            CSR_MINSTRET,  CSR_INSTRET:  rdata_h = instret_q.lo;
            CSR_MINSTRETH, CSR_INSTRETH: rdata_h = instret_q.hi;
            CSR_MCOUNTINHIBIT:           rdata_h = HALF_W'(inhibit_q);
            default: ;
         endcase
      end
   end

   assign csr_rdata = XLEN'(rdata_h);
   assign cycle_o   = cycle_q;
   assign instret_o = instret_q;

endmodule

// File: tb/tb_csr_counter_unit.sv
module tb_csr_counter_unit;

   logic        clk;
   logic        rst;
   logic        retire_valid;
   logic        csr_we;
   logic        csr_re;
   logic [11:0] csr_addr;
   logic [31:0] csr_wdata;
   logic [31:0] csr_rdata;
   logic        csr_illegal;
   logic [63:0] cycle_o;
   logic [63:0] instret_o;

   int n_chk  = 0;
   int n_pass = 0;

   // reference state
   logic [63:0] m_cyc, m_ins;
   logic [2:0]  m_inh;

   typedef struct {
      logic        we;
      logic        re;
      logic [11:0] addr;
      logic [31:0] wdata;
      logic        rv;
      logic        exp_ill;
   } vec_t;

   typedef struct {
      logic [31:0] rdata;
      logic        ill;
      logic [63:0] cyc;
      logic [63:0] ins;
   } exp_t;

   localparam int NV = 16;
   vec_t vecs[NV];
   exp_t sbq[$];

   csr_counter_unit #(.XLEN(32), .CNT_RST(64'h0)) dut (
      .clk          (clk),
      .rst          (rst),
      .retire_valid (retire_valid),
      .csr_we       (csr_we),
      .csr_re       (csr_re),
      .csr_addr     (csr_addr),
      .csr_wdata    (csr_wdata),
      .csr_rdata    (csr_rdata),
      .csr_illegal  (csr_illegal),
      .cycle_o      (cycle_o),
      .instret_o    (instret_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic bit is_rw(input logic [11:0] a);
      return a == 12'hB00 || a == 12'hB80 || a == 12'hB02 || a == 12'hB82 || a == 12'h320;
   endfunction

   function automatic bit is_ro(input logic [11:0] a);
      return a == 12'hC00 || a == 12'hC80 || a == 12'hC02 || a == 12'hC82;
   endfunction

   function automatic logic [31:0] model_rdata();
      if (rst || !csr_re) return 32'h0;
      case (csr_addr)
         12'hB00, 12'hC00: return m_cyc[31:0];
         12'hB80, 12'hC80: return m_cyc[63:32];
         12'hB02, 12'hC02: return m_ins[31:0];
         12'hB82, 12'hC82: return m_ins[63:32];
         12'h320:          return {29'h0, m_inh};
         default:          return 32'h0;
      endcase
   endfunction

   // Next model state from the inputs currently driven
   function automatic void model_next(output logic [63:0] nc, output logic [63:0] ni,
                                      output logic [2:0] nh);
      nc = m_cyc;
      ni = m_ins;
      nh = m_inh;
      if (!m_inh[0]) nc = m_cyc + 64'd1;
      if (retire_valid && !m_inh[2]) ni = m_ins + 64'd1;
      if (csr_we && is_rw(csr_addr)) begin
         case (csr_addr)
            12'hB00: nc = {m_cyc[63:32], csr_wdata};
            12'hB80: nc = {csr_wdata, m_cyc[31:0]};
            12'hB02: ni = {m_ins[63:32], csr_wdata};
            12'hB82: ni = {csr_wdata, m_ins[31:0]};
            default: nh = {csr_wdata[2], 1'b0, csr_wdata[0]};
         endcase
      end
   endfunction

   task automatic tick();
      logic [63:0] nc, ni;
      logic [2:0]  nh;
      @(posedge clk);
      if (rst) begin
         m_cyc = 64'h0; m_ins = 64'h0; m_inh = 3'b000;
      end else begin
         model_next(nc, ni, nh);
         m_cyc = nc; m_ins = ni; m_inh = nh;
      end
      #1;
   endtask

   task automatic drv(input logic we, input logic re, input logic [11:0] addr,
                      input logic [31:0] wdata, input logic rv);
      csr_we = we; csr_re = re; csr_addr = addr; csr_wdata = wdata; retire_valid = rv;
   endtask

   initial begin
      logic [63:0] c0, i0, nc, ni;
      logic [2:0]  nh;
      logic [31:0] s_rdata;
      logic        s_ill;
      exp_t        e;

      vecs[0]  = '{we:1'b0, re:1'b1, addr:12'hB00, wdata:32'h0,        rv:1'b0, exp_ill:1'b0};
      vecs[1]  = '{we:1'b0, re:1'b1, addr:12'hB80, wdata:32'h0,        rv:1'b1, exp_ill:1'b0};
      vecs[2]  = '{we:1'b0, re:1'b1, addr:12'hC02, wdata:32'h0,        rv:1'b1, exp_ill:1'b0};
      vecs[3]  = '{we:1'b1, re:1'b0, addr:12'hC80, wdata:32'h1234,     rv:1'b0, exp_ill:1'b1};
      vecs[4]  = '{we:1'b0, re:1'b1, addr:12'h7FF, wdata:32'h0,        rv:1'b0, exp_ill:1'b1};
      vecs[5]  = '{we:1'b1, re:1'b0, addr:12'h7FF, wdata:32'hDEAD,     rv:1'b0, exp_ill:1'b1};
      vecs[6]  = '{we:1'b1, re:1'b0, addr:12'hB02, wdata:32'h55,       rv:1'b1, exp_ill:1'b0};
      vecs[7]  = '{we:1'b0, re:1'b1, addr:12'hB02, wdata:32'h0,        rv:1'b1, exp_ill:1'b0};
      vecs[8]  = '{we:1'b1, re:1'b1, addr:12'hB82, wdata:32'hA5,       rv:1'b0, exp_ill:1'b0};
      vecs[9]  = '{we:1'b0, re:1'b1, addr:12'hB82, wdata:32'h0,        rv:1'b0, exp_ill:1'b0};
      vecs[10] = '{we:1'b1, re:1'b0, addr:12'h320, wdata:32'hFFFF_FFFF, rv:1'b1, exp_ill:1'b0};
      vecs[11] = '{we:1'b0, re:1'b1, addr:12'h320, wdata:32'h0,        rv:1'b1, exp_ill:1'b0};
      vecs[12] = '{we:1'b1, re:1'b0, addr:12'h320, wdata:32'h0,        rv:1'b1, exp_ill:1'b0};
      vecs[13] = '{we:1'b0, re:1'b1, addr:12'h321, wdata:32'h0,        rv:1'b0, exp_ill:1'b1};
      vecs[14] = '{we:1'b1, re:1'b0, addr:12'hC00, wdata:32'h1234,     rv:1'b0, exp_ill:1'b1};
      vecs[15] = '{we:1'b0, re:1'b0, addr:12'hB00, wdata:32'h0,        rv:1'b1, exp_ill:1'b0};

      m_cyc = 64'h0; m_ins = 64'h0; m_inh = 3'b000;
      rst = 1'b1;
      drv(1'b0, 1'b1, 12'hB00, 32'h0, 1'b0);
      #2;
      chk("rst_cycle",   cycle_o,     64'h0);
      chk("rst_instret", instret_o,   64'h0);
      chk("rst_rdata",   csr_rdata,   64'h0);
      chk("rst_illegal", csr_illegal, 64'h0);
      tick();
      rst = 1'b0;
      drv(1'b0, 1'b0, 12'h0, 32'h0, 1'b0);

      // free run after reset
      for (int i = 0; i < 10; i++) tick();
      chk("run10_cycle",   cycle_o,   64'd10);
      chk("run10_instret", instret_o, 64'd0);
      drv(1'b0, 1'b1, 12'hC00, 32'h0, 1'b0);
      #1;
      chk("run10_rd_cycle", csr_rdata, 64'd10);
      chk("run10_rd_ill",   csr_illegal, 64'd0);

      // low-half write then carry into the high half
      drv(1'b1, 1'b0, 12'hB00, 32'hFFFF_FFFE, 1'b0);
      tick();
      drv(1'b0, 1'b0, 12'h0, 32'h0, 1'b0);
      chk("carry_0", cycle_o, 64'h0000_0000_FFFF_FFFE);
      tick();
      chk("carry_1", cycle_o, 64'h0000_0000_FFFF_FFFF);
      tick();
      chk("carry_2", cycle_o, 64'h0000_0001_0000_0000);

      // instret 64-bit wrap
      drv(1'b1, 1'b0, 12'hB82, 32'hFFFF_FFFF, 1'b0);
      tick();
      drv(1'b1, 1'b0, 12'hB02, 32'hFFFF_FFFF, 1'b0);
      tick();
      chk("wrap_loaded", instret_o, 64'hFFFF_FFFF_FFFF_FFFF);
      drv(1'b0, 1'b0, 12'h0, 32'h0, 1'b1);
      tick();
      drv(1'b0, 1'b0, 12'h0, 32'h0, 1'b0);
      chk("wrap_zero", instret_o, 64'h0);
      chk("wrap_cycle", cycle_o, 64'h0000_0001_0000_0003);

      // inhibit both counters
      drv(1'b1, 1'b0, 12'h320, 32'h5, 1'b0);
      tick();
      c0 = m_cyc;
      i0 = m_ins;
      chk("inh_write_edge_counts", cycle_o, 64'h0000_0001_0000_0004);
      drv(1'b0, 1'b1, 12'h320, 32'h0, 1'b1);
      #1;
      chk("inh_rd", csr_rdata, 64'h5);
      for (int i = 0; i < 5; i++) tick();
      chk("inh_hold_cycle",   cycle_o,   c0);
      chk("inh_hold_instret", instret_o, i0);
      drv(1'b1, 1'b0, 12'h320, 32'h0, 1'b1);
      tick();
      chk("inh_clr_edge_cycle",   cycle_o,   c0);
      chk("inh_clr_edge_instret", instret_o, i0);
      drv(1'b0, 1'b0, 12'h0, 32'h0, 1'b1);
      tick();
      chk("inh_resume_cycle",   cycle_o,   c0 + 64'd1);
      chk("inh_resume_instret", instret_o, i0 + 64'd1);
      drv(1'b0, 1'b0, 12'h0, 32'h0, 1'b0);

      // table-driven vectors through the scoreboard
      for (int i = 0; i < NV; i++) begin
         drv(vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].wdata, vecs[i].rv);
         e.rdata = model_rdata();
         e.ill   = vecs[i].exp_ill;
         model_next(nc, ni, nh);
         e.cyc = nc;
         e.ins = ni;
         sbq.push_back(e);
         #1;
         s_rdata = csr_rdata;
         s_ill   = csr_illegal;
         tick();
         if (sbq.size() == 0) begin
            n_chk++;
            $display("FAIL v%0d_scoreboard: got empty queue required one entry", i);
         end else begin
            e = sbq.pop_front();
            chk($sformatf("v%0d_rdata", i),   s_rdata,   e.rdata);
            chk($sformatf("v%0d_illegal", i), s_ill,     e.ill);
            chk($sformatf("v%0d_cycle", i),   cycle_o,   e.cyc);
            chk($sformatf("v%0d_instret", i), instret_o, e.ins);
         end
      end
      drv(1'b0, 1'b0, 12'h0, 32'h0, 1'b0);

      // async reset mid-cycle during an instret write
      drv(1'b1, 1'b1, 12'hB02, 32'h999, 1'b0);
      #2;
      rst = 1'b1;
      m_cyc = 64'h0; m_ins = 64'h0; m_inh = 3'b000;
      #1;
      chk("arst_cycle",   cycle_o,     64'h0);
      chk("arst_instret", instret_o,   64'h0);
      chk("arst_rdata",   csr_rdata,   64'h0);
      chk("arst_illegal", csr_illegal, 64'h0);
      tick();
      drv(1'b0, 1'b0, 12'h0, 32'h0, 1'b0);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      chk("arst_restart_cycle",   cycle_o,   64'd3);
      chk("arst_restart_instret", instret_o, 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
